// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and widths for the instruction/data memory port arbiter.
package mem_pkg;
   localparam int WORD_W = 32;
   localparam int STRB_W = 4;

   typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;
   typedef enum logic {INSTR, DATA} grant_t;
endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Two-way round-robin tie-breaker: on a tie the requester not granted last wins.
module rr_pick2
   import mem_pkg::*;
(
   input  logic   elig_i,
   input  logic   elig_d,
   input  grant_t last_grant,
   output logic   valid,
   output grant_t grant
);
   always_comb begin
      valid = elig_i | elig_d;
      grant = INSTR;
      if (elig_i && elig_d)
         grant = (last_grant == INSTR) ? DATA : INSTR;
      else if (elig_d)
         grant = DATA;
   end
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and load/store, with redirect discard
// and a per-transaction timeout abort.
module mem_port_arbiter
   import mem_pkg::*;
#(
   parameter int unsigned AW      = 32,
   parameter int unsigned TIMEOUT = 64,
   parameter int unsigned CW      = 7
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_req,
   input  logic [AW-1:0]     i_addr,
   input  logic              i_flush,
   output logic              i_rdy,
   output logic [WORD_W-1:0] i_rdata,
   output logic              i_err,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [AW-1:0]     d_addr,
   input  logic [WORD_W-1:0] d_wdata,
   input  logic [STRB_W-1:0] d_wstrb,
   output logic              d_rdy,
   output logic [WORD_W-1:0] d_rdata,
   output logic              d_err,
   output logic              mem_req,
   output logic              mem_we,
   output logic [AW-1:0]     mem_addr,
   output logic [WORD_W-1:0] mem_wdata,
   output logic [STRB_W-1:0] mem_wstrb,
   input  logic              mem_drdy,
   input  logic [WORD_W-1:0] mem_rdata
);
   state_t        state;
   grant_t        last_grant;
   grant_t        grant;
   logic          grant_valid;
   logic          flush_pend;
   logic [CW-1:0] cnt;
   logic          timed_out;

   // A requester whose rdy is high this cycle is still finishing; don't regrant it.
   rr_pick2 u_pick (
      .elig_i     (i_req && !i_rdy),
      .elig_d     (d_req && !d_rdy),
      .last_grant (last_grant),
      .valid      (grant_valid),
      .grant      (grant)
   );

   assign timed_out = (cnt == CW'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         last_grant <= INSTR;
         flush_pend <= 1'b0;
         cnt        <= '0;
         i_rdy      <= 1'b0;
         i_rdata    <= '0;
         i_err      <= 1'b0;
         d_rdy      <= 1'b0;
         d_rdata    <= '0;
         d_err      <= 1'b0;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         mem_wstrb  <= '0;
      end else begin
         i_rdy <= 1'b0;
         d_rdy <= 1'b0;
         case (state)
            IDLE: begin
               flush_pend <= 1'b0;
               cnt        <= '0;
               if (grant_valid) begin
                  last_grant <= grant;
                  mem_req    <= 1'b1;
                  if (grant == DATA) begin
                     state     <= BUSY_D;
                     mem_we    <= d_we;
                     mem_addr  <= d_addr;
                     mem_wdata <= d_wdata;
                     mem_wstrb <= d_we ? d_wstrb : '0;
                  end else begin
                     state     <= BUSY_I;
                     mem_we    <= 1'b0;
                     mem_addr  <= i_addr;
                     mem_wdata <= '0;
                     mem_wstrb <= '0;
                  end
               end
            end
            BUSY_I: begin
               if (mem_drdy || timed_out) begin
                  state   <= IDLE;
                  mem_req <= 1'b0;
                  // A redirect seen at any point, including the final cycle, drops the result.
                  if (!(flush_pend || i_flush)) begin
                     i_rdy   <= 1'b1;
                     i_err   <= !mem_drdy;
                     i_rdata <= mem_drdy ? mem_rdata : '0;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
                  if (i_flush)
                     flush_pend <= 1'b1;
               end
            end
            BUSY_D: begin
               if (mem_drdy || timed_out) begin
                  state   <= IDLE;
                  mem_req <= 1'b0;
                  d_rdy   <= 1'b1;
                  d_err   <= !mem_drdy;
                  d_rdata <= (mem_drdy && !mem_we) ? mem_rdata : '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single instruction/data memory port between two requesters.
  - Instruction requester: the fetch stage, read-only, word-addressed by pc.
  - Data requester: the load/store stage, read/write.
- Sequences each transaction over the memory's drdy handshake and returns data and completion to the owner.
- Handles fetch redirects by discarding stale instruction reads.
- Aborts hung transactions with an error after a timeout.

Parameters:
- AW, 32, address width in bits (word address).
- TIMEOUT, 64, max BUSY cycles without mem_drdy before abort; must be >= 2.
- CW, 7, timeout counter width; must hold TIMEOUT.

Ports:
- clk  in  1  clock, all state on posedge.
- rst  in  1  synchronous reset, active-high.
- i_req  in  1  instruction read request; held until i_rdy.
- i_addr  in  AW  instruction word address; stable while i_req.
- i_flush  in  1  fetch redirect; in-flight instruction read is discarded.
- i_rdy  out  1  one-cycle completion pulse for the instruction read.
- i_rdata  out  32  instruction word; valid with i_rdy.
- i_err  out  1  timeout abort flag; valid with i_rdy.
- d_req  in  1  data request; held until d_rdy.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  AW  data word address.
- d_wdata  in  32  write data.
- d_wstrb  in  4  byte enables; forced to 0 on reads.
- d_rdy  out  1  one-cycle completion pulse for the data transaction.
- d_rdata  out  32  read data; 0 for writes.
- d_err  out  1  timeout abort flag; valid with d_rdy.
- mem_req  out  1  transaction active toward memory.
- mem_we  out  1  write enable.
- mem_addr  out  AW  address.
- mem_wdata  out  32  write data.
- mem_wstrb  out  4  byte enables.
- mem_drdy  in  1  memory completion, one cycle.
- mem_rdata  in  32  read data; valid with mem_drdy.

Behaviour:
- Reset values:
  - State IDLE.
  - All outputs 0.
  - last_grant = INSTR, so data wins the first tie.
  - Flush-pending flag 0; timeout counter 0.
- States: IDLE, BUSY_I, BUSY_D. All outputs are registered.
- IDLE
  - Eligible requester: req=1 and its own rdy is not high this cycle. The rdy cycle belongs to the finished transaction.
  - One eligible requester: grant it.
  - Both eligible: grant the one not equal to last_grant, then update last_grant.
  - On grant, latch addr/we/wdata/wstrb onto mem_*, set mem_req=1 next cycle, and enter BUSY_x.
  - mem_drdy in IDLE is ignored.
- BUSY_x
  - mem_req held at 1, mem_* held stable.
  - Timeout counter increments each cycle.
  - On mem_drdy=1: next cycle mem_req=0, x_rdy=1 for exactly one cycle, x_rdata=mem_rdata (0 for writes), x_err=0, state returns to IDLE.
- Latency:
  - Request seen in cycle N gives mem_req in N+1.
  - mem_drdy in cycle M gives rdy in M+1.
  - Minimum 3 cycles per transaction per requester.
  - The other requester can be granted in the rdy cycle.
- Timeout:
  - If the counter reaches TIMEOUT with no mem_drdy: mem_req drops, x_rdy=1 with x_err=1 and x_rdata=0, state goes to IDLE.
  - mem_drdy arriving in the same cycle the counter reaches TIMEOUT counts as normal completion.
- Flush:
  - i_flush=1 in BUSY_I, or in the cycle mem_drdy arrives, sets flush-pending.
  - The memory transaction still completes or times out, but i_rdy is suppressed and i_rdata is left unchanged.
  - Flush-pending clears on return to IDLE.
  - i_flush in IDLE or BUSY_D has no effect. i_flush during the i_rdy cycle has no effect.
- Data transactions are never flushed or suppressed.
- Reset mid-transaction: next cycle mem_req=0, no rdy pulse, pending results are discarded.
- A requester deasserting req mid-transaction is a protocol violation; the transaction completes regardless.

Decomposition:
- Shared package mem_pkg:
  - state enum {IDLE, BUSY_I, BUSY_D}.
  - Grant enum {INSTR, DATA}.
  - Constant WORD_W = 32.
  - Constant STRB_W = 4.
- Natural sub-module: rr_pick2, a combinational two-way tie-breaker taking eligibility flags and last_grant and returning the grant.
- FSM, timeout counter and flush flag stay in the top module.

Test Plan:
1. Single fetch: i_req=1, i_addr=0x10; memory drdy 2 cycles after mem_req, rdata=0x00000013 -> mem_addr=0x10 one cycle after request, mem_we=0, i_rdy=1 for one cycle, i_rdata=0x13, i_err=0.
2. Tie after reset: i_req and d_req both 1 in the same cycle (d_we=1, d_addr=0x20, d_wdata=0xDEADBEEF, d_wstrb=0xF) -> data granted first; write appears on mem_*; d_rdy then d_rdata=0; instruction granted in the d_rdy cycle.
3. Alternation: i_req and d_req held continuously for 4 transactions each -> grants strictly alternate D,I,D,I...; no requester is starved.
4. Flush: i_flush=1 while BUSY_I, mem_drdy 3 cycles later with rdata=0xFFFF -> no i_rdy pulse, i_rdata unchanged, then return to IDLE; a new fetch is then serviced normally.
5. Timeout: mem_drdy never asserted -> exactly TIMEOUT=64 cycles of mem_req, then mem_req=0, d_rdy=1, d_err=1, d_rdata=0; a late mem_drdy in IDLE is ignored.
6. Reset mid-BUSY_D: rst=1 for one cycle -> mem_req=0 and all rdy=0 next cycle; a mem_drdy arriving after reset produces no rdy pulse.
